// File: rtl/score_pkg.sv
// Shared definitions for the whack-a-mole score tracker: FSM encoding,
// default parameter values and the lane-index width helper.
package score_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PLAYING = ST_PLAYING,
        DONE    = ST_DONE
    } state_t;

    localparam int DEF_NUM_PLAYERS  = 2;
    localparam int DEF_SCORE_W      = 8;
    localparam int DEF_MAX_SCORE    = 200;
    localparam int DEF_STREAK_W     = 4;
    localparam int DEF_COMBO_THRESH = 3;
    localparam int DEF_COMBO_BONUS  = 1;
    localparam int DEF_MISS_PENALTY = 1;

    // Width of a lane index; never narrower than one bit.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_lane.sv
// One player's score and streak registers with combo bonus, miss penalty
// and clamping to [0, MAX_SCORE].
module score_lane
    import score_pkg::*;
#(
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int MAX_SCORE    = DEF_MAX_SCORE,
    parameter int STREAK_W     = DEF_STREAK_W,
    parameter int COMBO_THRESH = DEF_COMBO_THRESH,
    parameter int COMBO_BONUS  = DEF_COMBO_BONUS,
    parameter int MISS_PENALTY = DEF_MISS_PENALTY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               hit,
    input  logic               miss,
    output logic [SCORE_W-1:0] score
);

    localparam logic signed [SCORE_W+1:0] CEIL      = (SCORE_W+2)'(MAX_SCORE);
    localparam logic signed [SCORE_W+1:0] PEN       = (SCORE_W+2)'(MISS_PENALTY);
    localparam logic signed [SCORE_W+1:0] HIT_ADD   = (SCORE_W+2)'(1);
    localparam logic signed [SCORE_W+1:0] COMBO_ADD = (SCORE_W+2)'(1 + COMBO_BONUS);
    localparam logic [STREAK_W-1:0]       STREAK_MAX = {STREAK_W{1'b1}};

    logic [STREAK_W-1:0]       streak;
    logic signed [SCORE_W+1:0] score_wide;
    logic                      combo;

    // Two guard bits: one for the carry past MAX_SCORE, one for the sign
    // when the penalty would take the score below zero.
    function automatic logic [SCORE_W-1:0] clamp(input logic signed [SCORE_W+1:0] v);
        if (v > CEIL)
            return CEIL[SCORE_W-1:0];
        else if (v < 0)
            return '0;
        else
            return v[SCORE_W-1:0];
    endfunction

    assign score_wide = $signed({2'b00, score});
    assign combo      = int'(streak) >= COMBO_THRESH;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            score  <= '0;
            streak <= '0;
        end else if (enable) begin
            if (miss) begin
                score  <= clamp(score_wide - PEN);
                streak <= '0;
            end else if (hit) begin
                score  <= clamp(score_wide + (combo ? COMBO_ADD : HIT_ADD));
                if (streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Game-level score tracker: start/play/done FSM, per-lane scoring,
// winner/tie reduction at game end and a high score kept across games.
module score_tracker
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int MAX_SCORE    = DEF_MAX_SCORE,
    parameter int STREAK_W     = DEF_STREAK_W,
    parameter int COMBO_THRESH = DEF_COMBO_THRESH,
    parameter int COMBO_BONUS  = DEF_COMBO_BONUS,
    parameter int MISS_PENALTY = DEF_MISS_PENALTY,
    localparam int WIN_W       = lane_w(NUM_PLAYERS)
) (
    input  logic                           clkIn,
    input  logic                           reset,
    input  logic                           game_active,
    input  logic                           timer_expired,
    input  logic [NUM_PLAYERS-1:0]         hit,
    input  logic [NUM_PLAYERS-1:0]         miss,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic [SCORE_W-1:0]             high_score,
    output logic                           final_valid,
    output logic [WIN_W-1:0]               winner,
    output logic                           tie,
    output logic                           new_high_score
);

    state_t state, state_nxt;
    logic   clear, enable, done_now;

    logic [SCORE_W-1:0] lane_score [NUM_PLAYERS];
    logic [SCORE_W-1:0] max_val;
    logic [WIN_W-1:0]   win_val;
    logic               tie_val;
    int                 n_max;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
        score_lane #(
            .SCORE_W      (SCORE_W),
            .MAX_SCORE    (MAX_SCORE),
            .STREAK_W     (STREAK_W),
            .COMBO_THRESH (COMBO_THRESH),
            .COMBO_BONUS  (COMBO_BONUS),
            .MISS_PENALTY (MISS_PENALTY)
        ) u_lane (
            .clk    (clkIn),
            .reset  (reset),
            .clear  (clear),
            .enable (enable),
            .hit    (hit[i]),
            .miss   (miss[i]),
            .score  (lane_score[i])
        );
        assign score[i*SCORE_W +: SCORE_W] = lane_score[i];
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        enable    = 1'b0;
        done_now  = 1'b0;
        case (state)
            IDLE: begin
                if (game_active && !timer_expired) begin
                    clear     = 1'b1;
                    state_nxt = PLAYING;
                end
            end
            PLAYING: begin
                // Lanes are frozen on the exit cycle, so the values reduced
                // below are already the final ones.
                if (timer_expired || !game_active) begin
                    done_now  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    enable = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strict '>' keeps the lowest index on equal scores.
    always_comb begin
        max_val = '0;
        win_val = '0;
        n_max   = 0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (lane_score[i] > max_val) begin
                max_val = lane_score[i];
                win_val = WIN_W'(i);
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (lane_score[i] == max_val)
                n_max = n_max + 1;
        end
        tie_val = n_max > 1;
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state          <= IDLE;
            high_score     <= '0;
            final_valid    <= 1'b0;
            winner         <= '0;
            tie            <= 1'b0;
            new_high_score <= 1'b0;
        end else begin
            state          <= state_nxt;
            final_valid    <= done_now;
            new_high_score <= done_now && (max_val > high_score);
            if (done_now) begin
                winner <= win_val;
                tie    <= tie_val;
                if (max_val > high_score)
                    high_score <= max_val;
            end
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: a behavioural model queues the expected
// outputs for every driven cycle, which are compared after the clock edge.
module tb_score_tracker;

    logic        clkIn = 1'b0;
    logic        reset = 1'b0;
    logic        game_active = 1'b0;
    logic        timer_expired = 1'b0;
    logic [1:0]  hit = 2'b00;
    logic [1:0]  miss = 2'b00;
    logic [15:0] score;
    logic [7:0]  high_score;
    logic        final_valid;
    logic [0:0]  winner;
    logic        tie;
    logic        new_high_score;

    score_tracker dut (
        .clkIn          (clkIn),
        .reset          (reset),
        .game_active    (game_active),
        .timer_expired  (timer_expired),
        .hit            (hit),
        .miss           (miss),
        .score          (score),
        .high_score     (high_score),
        .final_valid    (final_valid),
        .winner         (winner),
        .tie            (tie),
        .new_high_score (new_high_score)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        int s0, s1, hs, fv, win, tie, nhs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int m_st = 0;
    int ms[2];
    int mk[2];
    int mhs = 0, mfv = 0, mwin = 0, mtie = 0, mnhs = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step(input logic [1:0] h, input logic [1:0] m,
                              input logic ga, input logic te, input logic rs);
        int mx;
        if (rs) begin
            m_st = 0; ms = '{0, 0}; mk = '{0, 0};
            mhs = 0; mfv = 0; mwin = 0; mtie = 0; mnhs = 0;
        end else begin
            mfv = 0; mnhs = 0;
            case (m_st)
                0: if (ga && !te) begin
                    ms = '{0, 0}; mk = '{0, 0}; m_st = 1;
                end
                1: if (te || !ga) begin
                    m_st = 2;
                    mx   = (ms[0] >= ms[1]) ? ms[0] : ms[1];
                    mwin = (ms[0] >= ms[1]) ? 0 : 1;
                    mtie = (ms[0] == ms[1]) ? 1 : 0;
                    mfv  = 1;
                    if (mx > mhs) begin mhs = mx; mnhs = 1; end
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (m[i]) begin
                            ms[i] = (ms[i] >= 1) ? ms[i] - 1 : 0;
                            mk[i] = 0;
                        end else if (h[i]) begin
                            ms[i] = ms[i] + 1 + ((mk[i] >= 3) ? 1 : 0);
                            if (ms[i] > 200) ms[i] = 200;
                            if (mk[i] < 15) mk[i] = mk[i] + 1;
                        end
                    end
                end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic cyc(input logic [1:0] h, input logic [1:0] m,
                       input logic ga, input logic te, input logic rs);
        exp_t e;
        hit = h; miss = m; game_active = ga; timer_expired = te; reset = rs;
        model_step(h, m, ga, te, rs);
        q.push_back('{ms[0], ms[1], mhs, mfv, mwin, mtie, mnhs});
        @(posedge clkIn);
        #1;
        e = q.pop_front();
        check_val("score0", int'(score[7:0]), e.s0);
        check_val("score1", int'(score[15:8]), e.s1);
        check_val("high_score", int'(high_score), e.hs);
        check_val("final_valid", int'(final_valid), e.fv);
        check_val("winner", int'(winner), e.win);
        check_val("tie", int'(tie), e.tie);
        check_val("new_high", int'(new_high_score), e.nhs);
        hit = 2'b00; miss = 2'b00;
    endtask

    // Spaced hit: pulse then one quiet cycle, game kept running.
    task automatic play(input logic [1:0] h, input logic [1:0] m);
        cyc(h, m, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("rst_score", int'(score), 0);
        check_val("rst_high", int'(high_score), 0);

        // Game 1: hits on the start cycle are ignored
        cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        check_val("start_clear", int'(score), 0);
        play(2'b01, 2'b00); check_val("p0_h1", int'(score[7:0]), 1);
        play(2'b01, 2'b00); check_val("p0_h2", int'(score[7:0]), 2);
        play(2'b01, 2'b00); check_val("p0_h3", int'(score[7:0]), 3);
        play(2'b01, 2'b00); check_val("p0_combo", int'(score[7:0]), 5);
        check_val("p1_idle", int'(score[15:8]), 0);
        play(2'b00, 2'b01); check_val("p0_miss", int'(score[7:0]), 4);
        play(2'b01, 2'b00); check_val("p0_after_miss", int'(score[7:0]), 5);
        play(2'b00, 2'b10); check_val("p1_floor", int'(score[15:8]), 0);
        play(2'b00, 2'b01); check_val("p0_miss2", int'(score[7:0]), 4);
        play(2'b01, 2'b01); check_val("hit_and_miss", int'(score[7:0]), 3);
        play(2'b11, 2'b00);
        check_val("both_p0", int'(score[7:0]), 4);
        check_val("both_p1", int'(score[15:8]), 1);
        play(2'b11, 2'b00); play(2'b11, 2'b00);     // 6/3, streaks 3/3
        play(2'b00, 2'b11);                         // 5/2, streaks 0/0
        play(2'b11, 2'b00); play(2'b01, 2'b00);     // 7/3
        play(2'b10, 2'b00);                         // 7/4
        check_val("pre_end_p0", int'(score[7:0]), 7);
        check_val("pre_end_p1", int'(score[15:8]), 4);
        // Hits on the expiry cycle are dropped
        cyc(2'b11, 2'b00, 1'b1, 1'b1, 1'b0);
        check_val("end_fv", int'(final_valid), 1);
        check_val("end_high", int'(high_score), 7);
        check_val("end_nhs", int'(new_high_score), 1);
        check_val("end_frozen", int'(score[7:0]), 7);
        cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        check_val("fv_pulse", int'(final_valid), 0);
        cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        check_val("idle_hold", int'(score), 16'h0407);

        // Game 2: ends tied 5/5 by dropping game_active
        cyc(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        check_val("g2_clear", int'(score), 0);
        for (int i = 0; i < 4; i++) play(2'b11, 2'b00);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check_val("g2_tie", int'(tie), 1);
        check_val("g2_winner", int'(winner), 0);
        check_val("g2_nhs", int'(new_high_score), 0);
        check_val("g2_high", int'(high_score), 7);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Game 3: saturation at MAX_SCORE
        cyc(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300 && ms[0] < 199; i++) cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        check_val("sat_199", int'(score[7:0]), 199);
        cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        check_val("sat_200", int'(score[7:0]), 200);
        cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        check_val("sat_hold", int'(score[7:0]), 200);
        cyc(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        check_val("g3_high", int'(high_score), 200);
        check_val("g3_nhs", int'(new_high_score), 1);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Game 4: reset mid-game, then hits in IDLE are ignored
        cyc(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        play(2'b11, 2'b00);
        cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b1);
        check_val("mid_rst_score", int'(score), 0);
        check_val("mid_rst_high", int'(high_score), 0);
        cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
        check_val("idle_ignore", int'(score), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
